// File: rtl/seq_div_pkg.sv
// Shared state encoding and default widths for the sequential restoring divider.
// SEQ_DIV_ROUND_EN adds the ROUND state used for round-half-up quotients.
package seq_div_pkg;

   localparam int DEF_DW = 12;
   localparam int DEF_VW = 5;

`ifdef SEQ_DIV_ROUND_EN
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2, ROUND = 2'd3} div_state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} div_state_t;
`endif

endpackage

// File: rtl/seq_sub_divider_sub_cell.sv
// One-bit full subtractor; chained ripple-borrow to form the trial subtraction.
module sub_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/seq_sub_divider.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
// Define SEQ_DIV_ROUND_EN to round the quotient half-up in one extra cycle.
module seq_sub_divider
   import seq_div_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int VW = DEF_VW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_zero
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   div_state_t    state_r, state_next;
   logic [DW-1:0] dvd_r;
   logic [VW-1:0] dvs_r;
   logic [VW-1:0] rem_r;
   logic [DW-1:0] quo_r;
   logic [CW-1:0] cnt_r;
   logic          div_zero_r;
   logic          in_ready_r;
   logic          out_valid_r;

   logic [VW:0]   trial_a_s;
   logic [VW:0]   trial_b_s;
   logic [VW:0]   trial_d_s;
   logic [VW+1:0] borrow_s;
   logic          div_by_zero_s;

   assign div_by_zero_s = (divisor == {VW{1'b0}});
   assign trial_a_s     = {rem_r, dvd_r[DW-1]};
   assign trial_b_s     = {1'b0, dvs_r};
   assign borrow_s[0]   = 1'b0;

   genvar gi;
   generate
      for (gi = 0; gi <= VW; gi++) begin : g_sub
         sub_cell u_cell (
            .a    (trial_a_s[gi]),
            .b    (trial_b_s[gi]),
            .bin  (borrow_s[gi]),
            .d    (trial_d_s[gi]),
            .bout (borrow_s[gi+1])
         );
      end
   endgenerate

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next;
      end
   end

   // Next-state decode
   always_comb begin
      state_next = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               state_next = div_by_zero_s ? DONE : CALC;
            end else begin
               state_next = IDLE;
            end
         end
         CALC: begin
            if (cnt_r == {CW{1'b0}}) begin
`ifdef SEQ_DIV_ROUND_EN
               state_next = ROUND;
`else
               state_next = DONE;
`endif
            end else begin
               state_next = CALC;
            end
         end
`ifdef SEQ_DIV_ROUND_EN
         ROUND: begin
            state_next = DONE;
         end
`endif
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end else begin
               state_next = DONE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Handshake flags registered from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         in_ready_r  <= (state_next == IDLE);
         out_valid_r <= (state_next == DONE);
      end
   end

   // Operand capture, restoring steps and optional rounding
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dvd_r      <= {DW{1'b0}};
         dvs_r      <= {VW{1'b0}};
         rem_r      <= {VW{1'b0}};
         quo_r      <= {DW{1'b0}};
         cnt_r      <= {CW{1'b0}};
         div_zero_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  dvd_r      <= dividend;
                  dvs_r      <= divisor;
                  cnt_r      <= CW'(DW - 1);
                  div_zero_r <= div_by_zero_s;
                  if (div_by_zero_s) begin
                     quo_r <= {DW{1'b1}};
                     rem_r <= dividend[VW-1:0];
                  end else begin
                     quo_r <= {DW{1'b0}};
                     rem_r <= {VW{1'b0}};
                  end
               end
            end
            CALC: begin
               dvd_r <= {dvd_r[DW-2:0], 1'b0};
               quo_r <= {quo_r[DW-2:0], ~borrow_s[VW+1]};
               // On borrow the shifted-in value is below the divisor, so it fits VW bits
               if (borrow_s[VW+1]) begin
                  rem_r <= trial_a_s[VW-1:0];
               end else begin
                  rem_r <= trial_d_s[VW-1:0];
               end
               if (cnt_r != {CW{1'b0}}) begin
                  cnt_r <= cnt_r - CW'(1);
               end
            end
`ifdef SEQ_DIV_ROUND_EN
            ROUND: begin
               if (({rem_r, 1'b0} >= {1'b0, dvs_r}) && (quo_r != {DW{1'b1}})) begin
                  quo_r <= quo_r + {{(DW-1){1'b0}}, 1'b1};
               end
            end
`endif
            DONE: begin
               quo_r <= quo_r;
            end
            default: begin
               quo_r <= quo_r;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign quotient  = quo_r;
   assign remainder = rem_r;
   assign div_zero  = div_zero_r;

endmodule

// File: tb/tb_seq_sub_divider.sv
// Directed scoreboard bench for seq_sub_divider; honours SEQ_DIV_ROUND_EN.
module tb_seq_sub_divider;

   localparam int DW = 12;
   localparam int VW = 5;
`ifdef SEQ_DIV_ROUND_EN
   localparam int LAT = DW + 2;
`else
   localparam int LAT = DW + 1;
`endif

   typedef struct packed {
      logic [DW-1:0] q;
      logic [VW-1:0] r;
      logic          dz;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_zero;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];

   seq_sub_divider #(.DW(DW), .VW(VW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b);
      exp_t e;
      if (b == 0) begin
         e.q  = {DW{1'b1}};
         e.r  = a[VW-1:0];
         e.dz = 1'b1;
      end else begin
         e.q  = a / b;
         e.r  = VW'(a % b);
         e.dz = 1'b0;
`ifdef SEQ_DIV_ROUND_EN
         if ((2 * int'(e.r) >= int'(b)) && (e.q != {DW{1'b1}})) e.q = e.q + 1'b1;
`endif
      end
      return e;
   endfunction

   // Accept one operand pair, check latency, hold in DONE for 'hold' cycles, then retire.
   task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input int hold);
      exp_t e;
      int   edges;
      int   want;
      check("in_ready_before_accept", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      sb.push_back(model(a, b));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      edges = 1;
      while (!out_valid && edges < 100) begin
         check("in_ready_busy", 32'(in_ready), 32'd0);
         @(posedge clk);
         @(negedge clk);
         edges++;
      end
      want = (b == 0) ? 1 : LAT;
      check("latency", 32'(edges), 32'(want));
      e = sb.pop_front();
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         check("hold_quotient", 32'(quotient), 32'(e.q));
         in_valid = i[0];
         dividend = DW'(i * 97);
         divisor  = VW'(i + 3);
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("out_valid", 32'(out_valid), 32'd1);
      check("quotient", 32'(quotient), 32'(e.q));
      check("remainder", 32'(remainder), 32'(e.r));
      check("div_zero", 32'(div_zero), 32'(e.dz));
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid_fall", 32'(out_valid), 32'd0);
      check("bubble_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_quotient", 32'(quotient), 32'd0);
      check("rst_remainder", 32'(remainder), 32'd0);
      check("rst_div_zero", 32'(div_zero), 32'd0);

      run_op(12'd4080, 5'd16, 0);
      run_op(12'd1000, 5'd7, 10);
      run_op(12'd37, 5'd0, 2);
      run_op(12'd3, 5'd20, 0);
      run_op(12'd2047, 5'd1, 0);
      run_op(12'd4095, 5'd31, 1);
      run_op(12'd4095, 5'd2, 0);
      run_op(12'd0, 5'd9, 0);

      // Abort an operation mid-CALC with an asynchronous reset pulse
      in_valid = 1'b1;
      dividend = 12'd1000;
      divisor  = 5'd7;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_out_valid", 32'(out_valid), 32'd0);
      check("async_rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("no_result_after_abort", 32'(out_valid), 32'd0);
      end
      check("in_ready_after_abort", 32'(in_ready), 32'd1);
      run_op(12'd9, 5'd3, 0);

      // Back-to-back operations: the bubble check in run_op covers acceptance spacing
      run_op(12'd100, 5'd10, 0);
      run_op(12'd101, 5'd10, 0);

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_sub_divider.md
SEQ_SUB_DIVIDER -- requirements
Module: seq_sub_divider

Interface
REQ-001 Parameter DW, default 12, dividend/quotient width (3x3 Gaussian weighted-sum width).
REQ-002 Parameter VW, default 5, divisor/remainder width; VW <= DW.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  dividend/divisor presented.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 dividend  input  DW  unsigned numerator.
REQ-008 divisor  input  VW  unsigned denominator.
REQ-009 out_valid  output  1  result held stable.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 quotient  output  DW  unsigned quotient.
REQ-012 remainder  output  VW  unsigned remainder.
REQ-013 div_zero  output  1  divisor was zero for current result.

Function
REQ-014 FSM states IDLE, CALC, DONE; only these three shall exist.
REQ-015 IDLE: in_ready=1; in_valid=1 latches dividend, divisor, clears partial remainder, loads step counter to DW-1, goes to CALC.
REQ-016 CALC: one restoring step per cycle, MSB first: trial = {partial_rem, next dividend bit} - divisor; borrow=0 -> keep trial, quotient bit 1; borrow=1 -> restore, quotient bit 0.
REQ-017 Trial subtraction width VW+1 bits; borrow is the MSB borrow-out of the sub_cell chain.
REQ-018 CALC lasts exactly DW cycles; after the step with counter 0 go to DONE.
REQ-019 Latency: accept edge to out_valid=1 is DW+1 cycles.
REQ-020 DONE: out_valid=1, in_ready=0; quotient/remainder/div_zero stable until out_ready=1.
REQ-021 DONE with out_ready=1: go to IDLE next cycle; no new operand accepted in the same cycle (one-cycle bubble).
REQ-022 in_ready=0 in CALC and DONE; in_valid ignored there.
REQ-023 divisor=0: skip CALC, go IDLE->DONE directly; quotient all ones, remainder = dividend[VW-1:0], div_zero=1.
REQ-024 dividend < divisor: quotient 0, remainder = dividend.
REQ-025 divisor=1: quotient = dividend, remainder 0.

Reset
REQ-026 rst asserted at any time, including mid-CALC or DONE, immediately forces IDLE and aborts any operation; no result emitted.
REQ-027 Reset values: in_ready=1 once rst deasserts, out_valid=0, quotient=0, remainder=0, div_zero=0, counter=0.

Configuration
REQ-028 Macro SEQ_DIV_ROUND_EN selects rounding.
REQ-029 Defined: one extra cycle after CALC; if 2*remainder >= divisor, quotient += 1 (saturating at all ones), remainder unchanged; latency DW+2.
REQ-030 Undefined: truncating quotient, latency DW+1, no rounding logic present.

Structure
REQ-031 Package seq_div_pkg holds the state enum (IDLE, CALC, DONE, plus ROUND when enabled) and default width constants.
REQ-032 One sub-module sub_cell: 1-bit full subtractor (a, b, bin -> d, bout), VW+1 instances chained ripple-borrow for trial subtraction.

Verification
REQ-033 dividend=4080, divisor=16 -> after 13 cycles quotient=255, remainder=0, div_zero=0.
REQ-034 dividend=1000, divisor=7 -> quotient=142, remainder=6; with SEQ_DIV_ROUND_EN quotient=143, after 14 cycles.
REQ-035 divisor=0, dividend=37 -> next cycle out_valid=1, quotient=4095, remainder=5, div_zero=1.
REQ-036 out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored.
REQ-037 rst pulse at CALC step 5 -> in_ready=1, out_valid=0 after release; next operand 9/3 -> quotient=3, remainder=0.
REQ-038 Back-to-back operands with out_ready=1 -> exactly one idle cycle between out_valid fall and next acceptance.
